// File: rtl/boot_rom_arb_pkg.sv
// Shared types and default constants for the two-port boot ROM arbiter.
package boot_rom_arb_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_8000;
  localparam int unsigned DEF_ROM_WORDS = 548;
  localparam int unsigned DEF_ROM_AW    = 10;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/boot_rom_addr_decode.sv
// Byte address to ROM word index translation with window range check.
module boot_rom_addr_decode
  import boot_rom_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned ROM_WORDS = DEF_ROM_WORDS,
  parameter int unsigned ROM_AW    = DEF_ROM_AW
) (
  input  logic [31:0]       addr,
  output logic              in_range,
  output logic [ROM_AW-1:0] index
);

  logic [31:0] offset;
  logic [29:0] word;

  // Below-base addresses wrap to huge offsets; the explicit compare rejects them.
  assign offset   = addr - BASE_ADDR;
  assign word     = 30'(offset >> 2);
  assign index    = ROM_AW'(word);
  assign in_range = (addr >= BASE_ADDR) && (32'(word) < ROM_WORDS);

endmodule

// File: rtl/boot_rom_arbiter.sv
// Two-port (instr/data) arbiter onto a single-cycle boot ROM.
// Define BOOT_ROM_ARB_RR_EN for round-robin arbitration; default is fixed instr priority.
module boot_rom_arbiter
  import boot_rom_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned ROM_WORDS = DEF_ROM_WORDS,
  parameter int unsigned ROM_AW    = DEF_ROM_AW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  input  logic [31:0]       data_addr_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_rdata_i
);

  logic              i_in_range, d_in_range;
  logic [ROM_AW-1:0] i_index, d_index;

  logic              gnt_valid;
  port_e             gnt_port;
  logic              gnt_in_range;
  logic [ROM_AW-1:0] gnt_index;
  logic              rom_hit;

  logic              pending_q;
  port_e             owner_q;
  logic              oor_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              rsp_valid;
  rsp_t              rsp;

  boot_rom_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .ROM_WORDS (ROM_WORDS),
    .ROM_AW    (ROM_AW)
  ) u_instr_dec (
    .addr     (instr_addr_i),
    .in_range (i_in_range),
    .index    (i_index)
  );

  boot_rom_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .ROM_WORDS (ROM_WORDS),
    .ROM_AW    (ROM_AW)
  ) u_data_dec (
    .addr     (data_addr_i),
    .in_range (d_in_range),
    .index    (d_index)
  );

`ifdef BOOT_ROM_ARB_RR_EN
  port_e prio_q;
`endif

  // Grant selection; a new grant may overlap the previous response cycle.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = PORT_INSTR;
    if (!RST) begin
      if (instr_req_i && data_req_i) begin
        gnt_valid = 1'b1;
`ifdef BOOT_ROM_ARB_RR_EN
        gnt_port  = prio_q;
`else
        gnt_port  = PORT_INSTR;
`endif
      end else if (instr_req_i) begin
        gnt_valid = 1'b1;
        gnt_port  = PORT_INSTR;
      end else if (data_req_i) begin
        gnt_valid = 1'b1;
        gnt_port  = PORT_DATA;
      end
    end
    gnt_in_range = (gnt_port == PORT_DATA) ? d_in_range : i_in_range;
    gnt_index    = (gnt_port == PORT_DATA) ? d_index : i_index;
    rom_hit      = gnt_valid && gnt_in_range;
  end

  assign instr_gnt_o = gnt_valid && (gnt_port == PORT_INSTR);
  assign data_gnt_o  = gnt_valid && (gnt_port == PORT_DATA);
  assign rom_csn_o   = !rom_hit;
  assign rom_addr_o  = RST ? '0 : (rom_hit ? gnt_index : rom_addr_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_q  <= 1'b0;
      owner_q    <= PORT_INSTR;
      oor_q      <= 1'b0;
      rom_addr_q <= '0;
`ifdef BOOT_ROM_ARB_RR_EN
      prio_q     <= PORT_INSTR;
`endif
    end else begin
      pending_q <= gnt_valid;
      if (gnt_valid) begin
        owner_q <= gnt_port;
        oor_q   <= !gnt_in_range;
`ifdef BOOT_ROM_ARB_RR_EN
        prio_q  <= (gnt_port == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
`endif
      end
      if (rom_hit) rom_addr_q <= gnt_index;
    end
  end

  // Response is steered to the owner only; RST masks any in-flight response.
  assign rsp_valid = pending_q && !RST;
  assign rsp.rdata = oor_q ? '0 : rom_rdata_i;
  assign rsp.err   = oor_q;

  assign instr_rvalid_o = rsp_valid && (owner_q == PORT_INSTR);
  assign data_rvalid_o  = rsp_valid && (owner_q == PORT_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? rsp.rdata : '0;
  assign instr_err_o    = instr_rvalid_o && rsp.err;
  assign data_rdata_o   = data_rvalid_o ? rsp.rdata : '0;
  assign data_err_o     = data_rvalid_o && rsp.err;

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Scoreboard bench for boot_rom_arbiter (either arbitration build).
module tb_boot_rom_arbiter;

  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam int unsigned WORDS = 548;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        instr_req_i = 1'b0, data_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0, data_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o;
  logic        rom_csn_o;
  logic [9:0]  rom_addr_o;
  logic [31:0] rom_rdata_i;

  boot_rom_arbiter dut (
    .CLK            (CLK),
    .RST            (RST),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .rom_csn_o      (rom_csn_o),
    .rom_addr_o     (rom_addr_o),
    .rom_rdata_i    (rom_rdata_i)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [9:0] idx);
    logic [31:0] v;
    v = 32'h0000_0013 + {2'b00, idx, 20'h0} + {22'h0, idx};
    return v;
  endfunction

  // Synchronous ROM: data for the selected word appears the cycle after select.
  always @(posedge CLK) if (!rom_csn_o) rom_rdata_i <= rom_word(rom_addr_o);

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        rsp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        i_want = 1'b0, d_want = 1'b0;
  logic [31:0] i_a = '0, d_a = '0;
  logic        prio = 1'b0;
  logic [9:0]  last_ra = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive requesters, check mid-cycle outputs, advance the model.
  task automatic step(input logic rst);
    logic        ig, dg, g, inr, gp;
    logic [31:0] ga, off;
    logic [9:0]  idx;
    exp_t        e;
    RST = rst;
    instr_req_i = i_want; instr_addr_i = i_a;
    data_req_i  = d_want; data_addr_i  = d_a;
    #4;
    ig = 1'b0; dg = 1'b0;
    if (!rst) begin
      if (i_want && d_want) begin
`ifdef BOOT_ROM_ARB_RR_EN
        ig = (prio == 1'b0); dg = (prio == 1'b1);
`else
        ig = 1'b1;
`endif
      end else begin
        ig = i_want; dg = d_want;
      end
    end
    g   = ig || dg;
    gp  = dg;
    ga  = dg ? d_a : i_a;
    off = ga - BASE;
    idx = off[11:2];
    inr = (ga >= BASE) && ((off >> 2) < WORDS);
    check("instr_gnt", 32'(instr_gnt_o), 32'(ig));
    check("data_gnt", 32'(data_gnt_o), 32'(dg));
    check("rom_csn", 32'(rom_csn_o), 32'(!(g && inr)));
    check("rom_addr", 32'(rom_addr_o), rst ? 32'h0 : 32'((g && inr) ? idx : last_ra));
    if (rst) rsp_q.delete();
    if (rsp_q.size() != 0) begin
      e = rsp_q.pop_front();
      check("instr_rvalid", 32'(instr_rvalid_o), 32'(e.port == 1'b0));
      check("data_rvalid", 32'(data_rvalid_o), 32'(e.port == 1'b1));
      check("rsp_rdata", e.port ? data_rdata_o : instr_rdata_o, e.rdata);
      check("rsp_err", 32'(e.port ? data_err_o : instr_err_o), 32'(e.err));
      check("idle_rdata", e.port ? instr_rdata_o : data_rdata_o, 32'h0);
      check("idle_err", 32'(e.port ? instr_err_o : data_err_o), 32'h0);
    end else begin
      check("rvalid_idle", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
      check("rdata_idle", instr_rdata_o | data_rdata_o, 32'h0);
      check("err_idle", {30'h0, instr_err_o, data_err_o}, 32'h0);
    end
    @(posedge CLK);
    #1;
    if (rst) begin
      prio = 1'b0;
      last_ra = '0;
    end else if (g) begin
      e.port  = gp;
      e.rdata = inr ? rom_word(idx) : 32'h0;
      e.err   = !inr;
      rsp_q.push_back(e);
      if (inr) last_ra = idx;
      prio = !gp;
      if (gp) d_want = 1'b0; else i_want = 1'b0;
    end
  endtask

  task automatic req_i(input logic [31:0] a); i_want = 1'b1; i_a = a; endtask
  task automatic req_d(input logic [31:0] a); d_want = 1'b1; d_a = a; endtask

  initial begin
    @(posedge CLK);
    #1;
    step(1'b1);
    step(1'b1);
    // Single in-range fetch of word 0
    req_i(32'h8000); step(1'b0); step(1'b0);
    // Contention
    req_i(32'h8004); req_d(32'h8008); step(1'b0); step(1'b0); step(1'b0);
    // Both held for four cycles
    for (int k = 0; k < 4; k++) begin
      req_i(32'h8010 + 32'(k * 4)); req_d(32'h8100 + 32'(k * 4)); step(1'b0);
    end
    step(1'b0); step(1'b0);
    // Range boundaries: last word, one past, just below base, unaligned
    req_d(32'h888C); step(1'b0);
    req_d(32'h8890); step(1'b0);
    req_d(32'h7FFC); step(1'b0);
    req_i(32'h8007); step(1'b0);
    step(1'b0); step(1'b0);
    // Reset right after a grant drops the response and restores priority
    req_d(32'h8020); step(1'b0);
    req_i(32'h8024); step(1'b0);
    req_i(32'h8028); req_d(32'h802C); step(1'b1);
    step(1'b0); step(1'b0); step(1'b0);
    // Streaming instruction fetch
    for (int k = 0; k < 8; k++) begin
      req_i(32'h8000 + 32'(k * 4)); step(1'b0);
    end
    step(1'b0);
    // Random traffic around the window edges
    for (int k = 0; k < 60; k++) begin
      if (!i_want && ($urandom_range(0, 3) != 0))
        req_i(32'h7FF0 + 32'($urandom_range(0, 32'h8A0)));
      if (!d_want && ($urandom_range(0, 2) != 0))
        req_d(32'h7FF0 + 32'($urandom_range(0, 32'h8A0)));
      step(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
    end
    i_want = 1'b0; d_want = 1'b0;
    step(1'b0); step(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boot_rom_arbiter.md
BOOT_ROM_ARBITER -- requirements
Module: boot_rom_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_8000, byte address of ROM word 0.
REQ-002 SHALL have parameter ROM_WORDS, default 548, number of valid ROM words.
REQ-003 SHALL have parameter ROM_AW, default 10, ROM word-address width.
REQ-004 SHALL have ports CLK in 1 (clock) and RST in 1 (reset; one clock; reset is synchronous and active-high).
REQ-005 SHALL have ports instr_req_i in 1, instr_addr_i in 32 (byte address), instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32, instr_err_o out 1.
REQ-006 SHALL have ports data_req_i in 1, data_addr_i in 32, data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32, data_err_o out 1.
REQ-007 SHALL have ports rom_csn_o out 1 (active-low select), rom_addr_o out ROM_AW (word address), rom_rdata_i in 32.

Function
REQ-008 SHALL assert at most one gnt per cycle, combinationally in the cycle the granted req is high.
REQ-009 SHALL decode word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
REQ-010 SHALL treat an address as in range iff addr >= BASE_ADDR and word index < ROM_WORDS.
REQ-011 SHALL, on granting an in-range request, drive rom_csn_o=0 and rom_addr_o=index in the grant cycle; otherwise rom_csn_o=1 and rom_addr_o holds its last value.
REQ-012 SHALL, on granting an out-of-range request, leave rom_csn_o=1.
REQ-013 SHALL assert the owner's rvalid for exactly one cycle, the cycle after its grant (latency 1).
REQ-014 SHALL drive the rvalid port's rdata = rom_rdata_i with err=0 for in-range reads; for out-of-range reads, rdata=0 and err=1.
REQ-015 SHALL hold rdata=0 and err=0 on any port whose rvalid is low.
REQ-016 SHALL support back-to-back grants: one grant per cycle, with a new grant allowed in the same cycle as the previous rvalid.
REQ-017 SHALL track response ownership in one registered owner field plus a pending flag; a single outstanding response maximum.
REQ-018 SHALL, when both req are high, arbitrate per REQ-024/REQ-025; the losing requester keeps req/addr stable and is granted in a later cycle.
REQ-019 SHALL require requesters to hold req and addr stable until gnt; the arbiter does not latch ungranted requests.

Reset
REQ-020 SHALL, while RST=1 at a CLK edge, clear pending and owner and reset the priority pointer to the instr port.
REQ-021 SHALL drive, while RST=1, all gnt/rvalid/err=0, all rdata=0, rom_csn_o=1 and rom_addr_o=0.
REQ-022 SHALL drop any response pending when RST asserts; no rvalid issues after reset for pre-reset grants.
REQ-023 SHALL issue no grant in a cycle where RST=1.

Configuration
REQ-024 SHALL, without macro BOOT_ROM_ARB_RR_EN, use fixed priority: instr beats data.
REQ-025 SHALL, with BOOT_ROM_ARB_RR_EN defined, use round-robin: on contention the port not granted most recently wins; the pointer updates on every grant.

Structure
REQ-026 SHALL place the port enum (PORT_INSTR, PORT_DATA), the response struct (rdata, err) and the default parameter constants in package boot_rom_arb_pkg.
REQ-027 SHALL implement the range check and index computation in sub-module boot_rom_addr_decode, instantiated once per port.

Verification
REQ-028 SHALL cover: instr_req, addr 0x8000 (rom_rdata_i=0x13) -> gnt same cycle, csn=0, rom_addr=0; instr_rvalid next cycle, rdata=0x00000013, err=0.
REQ-029 SHALL cover: both req, instr 0x8004, data 0x8008, fixed build -> instr granted cycle N, data granted N+1, rvalids at N+1 and N+2.
REQ-030 SHALL cover: RR build, both req held for 4 cycles -> grants alternate instr, data, instr, data.
REQ-031 SHALL cover: data_req to 0x8890 (index 548) and to 0x7FFC -> gnt, csn=1, data_rvalid next cycle with err=1, rdata=0.
REQ-032 SHALL cover: RST=1 in the cycle after a grant -> no rvalid, outputs at reset values, instr priority restored.
REQ-033 SHALL cover: continuous instr_req over 0x8000..0x801C -> 8 consecutive grants and 8 consecutive rvalids, each with the expected word.
